// File: rtl/crypto_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crypto_pkg
// Shared definitions for the modular arithmetic blocks (modular_mult,
// modular_exp): the sequencing FSM state type and the default operand width.
// No ports.
// ---------------------------------------------------------------------------
package crypto_pkg;

   localparam int DEFAULT_N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/modmul_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modmul_step
// One iteration of interleaved shift-add modular multiplication:
//    r_next = ((2*r mod m) + (y_bit ? x : 0)) mod m
// Pure combinational. Requires r < m and x < m, so every intermediate value
// fits in n+1 bits. m = 0 forces the result to 0.
// Ports:
//    r      in  n   current accumulator (< m)
//    x      in  n   multiplicand (< m)
//    m      in  n   modulus
//    y_bit  in  1   current multiplier bit
//    r_next out n   updated accumulator (< m)
// ---------------------------------------------------------------------------
module modmul_step
   import crypto_pkg::*;
#(
   parameter int n = DEFAULT_N
) (
   input  logic [n-1:0] r,
   input  logic [n-1:0] x,
   input  logic [n-1:0] m,
   input  logic         y_bit,
   output logic [n-1:0] r_next
);

   logic [n:0] m_ext;
   logic [n:0] dbl;
   logic [n:0] red1;
   logic [n:0] acc;

   always_comb begin
      m_ext = {1'b0, m};
      dbl   = {r, 1'b0};
      // 2r < 2m, so a single conditional subtraction brings it back below m
      red1  = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
      acc   = red1 + (y_bit ? {1'b0, x} : '0);
      if (m == '0) begin
         // Degenerate modulus: define the product as 0 rather than let 2r grow
         r_next = '0;
      end else if (acc >= m_ext) begin
         r_next = n'(acc - m_ext);
      end else begin
         r_next = acc[n-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/modular_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modular_mult
// Sequential modular multiplier: P = (X*Y) mod M, one bit of Y per clock,
// MSB first. A start sampled in IDLE latches the operands; n CALC cycles
// follow, then a single DONE cycle in which done is high.
// Ports:
//    clk      in  1  clock, rising edge
//    n_reset  in  1  asynchronous active-low reset
//    start    in  1  launch request, only honoured in IDLE
//    X        in  n  multiplicand, must be < M
//    Y        in  n  multiplier
//    M        in  n  modulus
//    P        out n  registered result, updated only on completion
//    done     out 1  registered one-cycle completion strobe
// ---------------------------------------------------------------------------
module modular_mult
   import crypto_pkg::*;
#(
   parameter int n = DEFAULT_N
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         start,
   input  logic [n-1:0] X,
   input  logic [n-1:0] Y,
   input  logic [n-1:0] M,
   output logic [n-1:0] P,
   output logic         done
);

   localparam int IW = (n > 1) ? $clog2(n) : 1;

   state_t        state;
   state_t        state_next;
   logic [n-1:0]  x_q;
   logic [n-1:0]  y_q;
   logic [n-1:0]  m_q;
   logic [n-1:0]  r;
   logic [n-1:0]  r_next;
   logic [IW-1:0] idx;
   logic          y_bit;

   assign y_bit = y_q[idx];

   modmul_step #(
      .n (n)
   ) u_step (
      .r      (r),
      .x      (x_q),
      .m      (m_q),
      .y_bit  (y_bit),
      .r_next (r_next)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (idx == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         x_q  <= '0;
         y_q  <= '0;
         m_q  <= '0;
         r    <= '0;
         idx  <= '0;
         P    <= '0;
         done <= 1'b0;
      end else begin
         // done mirrors the DONE state, registered so it is glitch-free
         done <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  x_q <= X;
                  y_q <= Y;
                  m_q <= M;
                  r   <= '0;
                  idx <= IW'(n - 1);
               end
            end
            CALC: begin
               r <= r_next;
               if (idx == '0) begin
                  P <= r_next;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_modular_mult.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_modular_mult
// Scoreboard bench for modular_mult (n = 8). Stimulus pushes the expected
// product and launch cycle; a monitor pops on each done pulse and checks
// P, latency and pulse width.
// ---------------------------------------------------------------------------
module tb_modular_mult;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         n_reset;
   logic         start;
   logic [N-1:0] X;
   logic [N-1:0] Y;
   logic [N-1:0] M;
   logic [N-1:0] P;
   logic         done;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   logic prev_done = 1'b0;

   typedef struct {
      logic [N-1:0] p;
      int           launch;
   } exp_t;

   exp_t sb[$];

   modular_mult #(.n(N)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .start   (start),
      .X       (X),
      .Y       (Y),
      .M       (M),
      .P       (P),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] ref_mod(int x, int y, int m);
      if (m == 0) return '0;
      return N'((x * y) % m);
   endfunction

   task automatic check(string name, longint act, longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: sample 1ns after the rising edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (n_reset && done) begin
         check("done_width", longint'(prev_done), 0);
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("P", P, e.p);
            check("latency", cyc - e.launch, N);
         end
      end
      prev_done = done;
   end

   task automatic issue(int x, int y, int m);
      exp_t e;
      @(negedge clk);
      X = N'(x);
      Y = N'(y);
      M = N'(m);
      start = 1'b1;
      e.p = ref_mod(x, y, m);
      e.launch = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 60 && (sb.size() != 0 || done); k++) @(negedge clk);
      check("drain", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   m, x, y;
      n_reset = 1'b0;
      start   = 1'b0;
      X = '0; Y = '0; M = '0;
      #2;
      check("reset_P", P, 0);
      check("reset_done", done, 0);
      repeat (2) @(negedge clk);
      n_reset = 1'b1;

      // Directed vectors
      issue(7, 2, 10);     wait_idle(); check("P_7x2m10", P, 4);
      issue(13, 11, 17);   wait_idle(); check("P_13x11m17", P, 7);
      issue(200, 255, 251); wait_idle(); check("P_200x255m251", P, 47);
      repeat (5) @(negedge clk);
      check("P_hold_idle", P, 47);
      issue(0, 5, 1);      wait_idle(); check("P_m1", P, 0);
      issue(7, 2, 10);     wait_idle();
      issue(5, 9, 0);      wait_idle(); check("P_m0", P, 0);

      // Operand changes and start pulse during CALC are ignored
      issue(7, 2, 10);
      @(negedge clk);
      X = 8'd99; Y = 8'd3; M = 8'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("P_no_restart", P, 4);

      // start held 3 cycles: exactly one operation
      @(negedge clk);
      X = 8'd7; Y = 8'd2; M = 8'd10; start = 1'b1;
      e.p = 8'd4; e.launch = cyc + 1; sb.push_back(e);
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_idle();

      // start held through done: a second operation launches from IDLE
      @(negedge clk);
      X = 8'd7; Y = 8'd2; M = 8'd10; start = 1'b1;
      e.p = 8'd4; e.launch = cyc + 1; sb.push_back(e);
      e.launch = e.launch + N + 2; sb.push_back(e);
      for (int k = 0; k < 30 && !done; k++) @(negedge clk);
      check("done_seen", done, 1);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset during the 3rd CALC cycle aborts the operation
      issue(13, 11, 17);
      @(negedge clk);
      @(negedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      check("abort_P", P, 0);
      check("abort_done", done, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      repeat (12) @(negedge clk);
      issue(7, 2, 10);     wait_idle(); check("P_after_reset", P, 4);

      // Random operations against the arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         m = int'($urandom_range(2, 255));
         x = int'($urandom_range(0, m - 1));
         y = int'($urandom_range(0, 255));
         issue(x, y, m);
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
